// File: rtl/csr_file_mmode_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR file:
//   - CSR address map
//   - wr_op encodings
//   - mstatus / mip bit positions
//   - interrupt cause values
//   - mtvec mode enum
//   - a snapshot struct of all readable CSRs
//   - decode / read / read-modify-write helpers
// These helpers are shared by the ID read port and the WB write port.
// No ports (package).
// -----------------------------------------------------------------------------
package csr_pkg;

  localparam int CSR_XLEN = 32;

  // CSR address map
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // CSR instruction flavours as seen on wr_op
  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_RW   = 2'b01,
    WR_RS   = 2'b10,
    WR_RC   = 2'b11
  } wr_op_e;

  // mstatus fields
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP0 = 11;
  localparam int MSTATUS_MPP1 = 12;

  // mip / mie fields
  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  // Interrupt cause values
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  // misa reads as zero: the ISA is not reported through this register.
  localparam logic [31:0] MISA_VAL = 32'h0000_0000;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  // Current architectural value of every readable CSR.
  // Counters are always held at 64 bits here, zero-extended.
  typedef struct packed {
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mip;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [31:0] mhartid;
  } csr_view_t;

  function automatic logic csr_implemented(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic csr_read_only(input logic [11:0] a);
    case (a)
      CSR_MISA, CSR_MIP, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_read(input logic [11:0] a,
                                           input csr_view_t v);
    case (a)
      CSR_MSTATUS:   return v.mstatus;
      CSR_MISA:      return MISA_VAL;
      CSR_MIE:       return v.mie;
      CSR_MTVEC:     return v.mtvec;
      CSR_MSCRATCH:  return v.mscratch;
      CSR_MEPC:      return v.mepc;
      CSR_MCAUSE:    return v.mcause;
      CSR_MTVAL:     return v.mtval;
      CSR_MIP:       return v.mip;
      CSR_MCYCLE:    return v.mcycle[31:0];
      CSR_MCYCLEH:   return v.mcycle[63:32];
      CSR_MINSTRET:  return v.minstret[31:0];
      CSR_MINSTRETH: return v.minstret[63:32];
      CSR_MHARTID:   return v.mhartid;
      default:       return 32'h0;
    endcase
  endfunction

  // Read-modify-write result of a CSR instruction
  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src);
    case (op)
      WR_RW:   return src;
      WR_RS:   return old_val | src;
      WR_RC:   return old_val & ~src;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_mmode_if.sv
// -----------------------------------------------------------------------------
// csr_file_mmode_if
// CSR access bus between the pipeline and the CSR file.
//   rd_addr / rd_data / rd_illegal   : ID-stage read port
//   wr_op / wr_addr / wr_src         : WB-stage write command
//   wr_illegal                       : write command targets a RO/unknown CSR
// Modports: master (pipeline side), slave (CSR file).
//
// Handshake semantics: there is no valid/ready pair.
//   - The read port is purely combinational.
//   - wr_op != 00 is a single-cycle command.
//   - It commits at the next rising clock edge unless a trap or mret
//     retires in the same cycle.
//   - There is no backpressure.
// -----------------------------------------------------------------------------
interface csr_file_mmode_if #(
  parameter int XLEN = 32
);
  logic [11:0]     rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_illegal;
  logic [1:0]      wr_op;
  logic [11:0]     wr_addr;
  logic [XLEN-1:0] wr_src;
  logic            wr_illegal;

  modport master (
    output rd_addr, wr_op, wr_addr, wr_src,
    input  rd_data, rd_illegal, wr_illegal
  );

  modport slave (
    input  rd_addr, wr_op, wr_addr, wr_src,
    output rd_data, rd_illegal, wr_illegal
  );
endinterface

// File: rtl/csr_file_mmode_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
// CNT_W-bit free-running counter, readable and writable as two 32-bit halves.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one this cycle
//   wr_lo      : load bits [31:0] from wr_data
//   wr_hi      : load bits [63:32] from wr_data (bits above CNT_W are dropped)
//   wr_data    : write data
//   value      : current count
// Write behaviour:
//   - A write to either half suppresses the increment for that cycle.
//   - The other half holds.
//   - So a low-half write of all-ones never carries into the high half
//     on the same edge.
// The count wraps to 0 at 2^CNT_W.
// -----------------------------------------------------------------------------
module csr_counter #(
  parameter int CNT_W = 64,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wr_data,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      cur64;
  logic [63:0]      nxt64;

  // Work in a 64-bit frame so both halves always exist.
  // Truncation back to CNT_W provides the wrap.
  assign cur64 = 64'(cnt_q);

  always_comb begin
    nxt64 = cur64;
    if (wr_lo || wr_hi) begin
      if (wr_lo) nxt64[31:0]  = wr_data[31:0];
      if (wr_hi) nxt64[63:32] = wr_data[31:0];
    end else if (inc) begin
      nxt64 = cur64 + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= nxt64[CNT_W-1:0];
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_file_mmode.sv
// -----------------------------------------------------------------------------
// csr_file_mmode
// Machine-mode CSR file.
//
// Features:
//   - RW/RS/RC CSR operations
//   - mie/mip interrupt handling
//   - trap entry and mret
//   - direct or vectored mtvec
//   - 64-bit cycle/instret counters
//
// Optional build macro CSR_COUNTERS_EN:
//   - Defined: mcycle/minstret (+ high halves) are live counters.
//   - Undefined: no counter flops. The counter addresses:
//       * read as 0 and are not flagged illegal,
//       * silently ignore writes,
//       * leave instret_inc unused.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : rd_addr/rd_data/rd_illegal (ID),
//                     wr_op/wr_addr/wr_src/wr_illegal (WB)
//   trap_en         : take a trap at this edge (with trap_pc/trap_cause/trap_tval)
//   mret_en         : mret retires at this edge
//   instret_inc     : one instruction retired this cycle
//   irq_sw/timer/ext: level interrupt inputs, registered once into mip
//   irq_pending     : global MIE set and an enabled interrupt is pending
//   irq_cause       : cause of the highest-priority pending interrupt, else 0
//   trap_vector     : handler PC for the current trap_cause
//   mepc_out        : current mepc, consumed by mret
//
// Precedence at a clock edge:
//   - trap_en beats mret_en, which beats a CSR write.
//   - A losing write is dropped.
// -----------------------------------------------------------------------------
module csr_file_mmode
  import csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] HART_ID   = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_file_mmode_if.slave bus,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_en,
  input  logic            instret_inc,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            irq_pending,
  output logic [XLEN-1:0] irq_cause,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out
);

  // A reset value with mode 1x is not a legal mode; fall back to direct.
  localparam mtvec_mode_e MTVEC_RST_MODE =
    MTVEC_RST[1] ? MTVEC_DIRECT : mtvec_mode_e'({1'b0, MTVEC_RST[0]});

  // Architectural state
  logic        mst_mie_q;
  logic        mst_mpie_q;
  logic [31:0] mie_q;
  logic [31:2] mtvec_base_q;
  mtvec_mode_e mtvec_mode_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip_q;

  logic [63:0] cycle_val;
  logic [63:0] instret_val;

  csr_view_t   view;
  logic [31:0] mip_d;
  logic [31:0] wr_old;
  logic [31:0] wr_new;
  logic        wr_commit;
  logic [31:0] mtvec_base;
  logic [31:0] irq_active;

  // Snapshot of all readable CSRs, shared by the read port and the RMW path
  always_comb begin
    view                       = '0;
    view.mstatus[MSTATUS_MIE]  = mst_mie_q;
    view.mstatus[MSTATUS_MPIE] = mst_mpie_q;
    view.mstatus[MSTATUS_MPP0] = 1'b1;
    view.mstatus[MSTATUS_MPP1] = 1'b1;
    view.mie                   = mie_q;
    view.mtvec                 = {mtvec_base_q, mtvec_mode_q};
    view.mscratch              = mscratch_q;
    view.mepc                  = mepc_q;
    view.mcause                = mcause_q;
    view.mtval                 = mtval_q;
    view.mip                   = mip_q;
    view.mcycle                = cycle_val;
    view.minstret              = instret_val;
    view.mhartid               = HART_ID;
  end

  // Read port: no bypass from a same-cycle write, the pipeline owns that hazard
  assign bus.rd_data    = csr_read(bus.rd_addr, view);
  assign bus.rd_illegal = !csr_implemented(bus.rd_addr);

  // RS/RC with a zero source still goes through here; it just rewrites the
  // old value, and is illegal only if the address itself is.
  assign bus.wr_illegal = (bus.wr_op != WR_NONE) &&
                          (!csr_implemented(bus.wr_addr) ||
                           csr_read_only(bus.wr_addr));
  assign wr_old    = csr_read(bus.wr_addr, view);
  assign wr_new    = csr_apply(bus.wr_op, wr_old, bus.wr_src);
  assign wr_commit = (bus.wr_op != WR_NONE) && !bus.wr_illegal &&
                     !trap_en && !mret_en;

  // Raw interrupt lines, registered once into mip
  always_comb begin
    mip_d           = '0;
    mip_d[MIP_MSIP] = irq_sw;
    mip_d[MIP_MTIP] = irq_timer;
    mip_d[MIP_MEIP] = irq_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q    <= 1'b0;
      mst_mpie_q   <= 1'b0;
      mie_q        <= '0;
      mtvec_base_q <= MTVEC_RST[31:2];
      mtvec_mode_q <= MTVEC_RST_MODE;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mip_q        <= '0;
    end else begin
      mip_q <= mip_d;
      if (trap_en) begin
        mepc_q     <= trap_pc & ~32'h3;
        mcause_q   <= trap_cause;
        mtval_q    <= trap_tval;
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
      end else if (mret_en) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else if (wr_commit) begin
        case (bus.wr_addr)
          CSR_MSTATUS: begin
            mst_mie_q  <= wr_new[MSTATUS_MIE];
            mst_mpie_q <= wr_new[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q <= wr_new & IRQ_MASK;
          CSR_MTVEC: begin
            // Reserved modes (1x) keep the old mode but still load the base
            mtvec_base_q <= wr_new[31:2];
            if (!wr_new[1]) mtvec_mode_q <= mtvec_mode_e'({1'b0, wr_new[0]});
          end
          CSR_MSCRATCH: mscratch_q <= wr_new;
          CSR_MEPC:     mepc_q     <= wr_new & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= wr_new;
          CSR_MTVAL:    mtval_q    <= wr_new;
          // Counter addresses are handled by the counter instances
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic             cyc_wr_lo;
  logic             cyc_wr_hi;
  logic             ins_wr_lo;
  logic             ins_wr_hi;

  assign cyc_wr_lo = wr_commit && (bus.wr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = wr_commit && (bus.wr_addr == CSR_MCYCLEH);
  assign ins_wr_lo = wr_commit && (bus.wr_addr == CSR_MINSTRET);
  assign ins_wr_hi = wr_commit && (bus.wr_addr == CSR_MINSTRETH);

  csr_counter #(.CNT_W(CNT_W), .XLEN(32)) u_cycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (1'b1),
    .wr_lo   (cyc_wr_lo),
    .wr_hi   (cyc_wr_hi),
    .wr_data (wr_new),
    .value   (cycle_q)
  );

  csr_counter #(.CNT_W(CNT_W), .XLEN(32)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (instret_inc),
    .wr_lo   (ins_wr_lo),
    .wr_hi   (ins_wr_hi),
    .wr_data (wr_new),
    .value   (instret_q)
  );

  assign cycle_val   = 64'(cycle_q);
  assign instret_val = 64'(instret_q);
`else
  logic unused_instret_inc;
  assign unused_instret_inc = instret_inc;
  assign cycle_val          = '0;
  assign instret_val        = '0;
`endif

  // Interrupts: MEI > MSI > MTI; cause reads 0 whenever nothing would be taken
  assign irq_active  = mip_q & mie_q;
  assign irq_pending = mst_mie_q && (irq_active != 32'h0);

  always_comb begin
    irq_cause = '0;
    if (irq_pending) begin
      if (irq_active[MIP_MEIP])      irq_cause = CAUSE_MEI;
      else if (irq_active[MIP_MSIP]) irq_cause = CAUSE_MSI;
      else                           irq_cause = CAUSE_MTI;
    end
  end

  // Vectored mode offsets interrupts by 4*cause; exceptions always use the base
  assign mtvec_base  = {mtvec_base_q, 2'b00};
  assign trap_vector = (mtvec_mode_q == MTVEC_VECTORED && trap_cause[31])
                       ? mtvec_base + {trap_cause[29:0], 2'b00}
                       : mtvec_base;

  assign mepc_out = mepc_q;

endmodule

// File: tb/tb_csr_file_mmode.sv
// -----------------------------------------------------------------------------
// tb_csr_file_mmode
// Directed and randomized bench for csr_file_mmode.
// A CSR-level reference model predicts every output:
//   - one variable per register,
//   - counters held as 64-bit integers,
//   - updated once per rising edge from the applied inputs.
// Counter expectations follow CSR_COUNTERS_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_csr_file_mmode;

  localparam int          CNT_W     = 64;
  localparam logic [31:0] HART_ID   = 32'h0000_0005;
  localparam logic [31:0] MTVEC_RST = 32'h0000_2001;
  localparam longint unsigned CNT_MASK =
    (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);
`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  // ---------------- DUT ----------------
  logic        trap_en, mret_en, instret_inc;
  logic        irq_sw, irq_timer, irq_ext;
  logic [31:0] trap_pc, trap_cause, trap_tval;
  logic        irq_pending;
  logic [31:0] irq_cause, trap_vector, mepc_out;

  csr_file_mmode_if #(.XLEN(32)) bus ();

  csr_file_mmode #(
    .XLEN(32), .CNT_W(CNT_W), .HART_ID(HART_ID), .MTVEC_RST(MTVEC_RST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .trap_en     (trap_en),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .mret_en     (mret_en),
    .instret_inc (instret_inc),
    .irq_sw      (irq_sw),
    .irq_timer   (irq_timer),
    .irq_ext     (irq_ext),
    .irq_pending (irq_pending),
    .irq_cause   (irq_cause),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit              m_mie, m_mpie;
  logic [31:0]     m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [31:0]     m_mip;
  longint unsigned m_cycle, m_instret;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                     12'hB82, 12'hF14};
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    return a inside {12'h301, 12'h344, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [63:0] c, r;
    c = CNT_EN ? m_cycle : 64'h0;
    r = CNT_EN ? m_instret : 64'h0;
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return c[31:0];
      12'hB80: return c[63:32];
      12'hB02: return r[31:0];
      12'hB82: return r[63:32];
      12'hF14: return HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_irq_cause();
    logic [31:0] act;
    act = m_mip & m_mie_reg;
    if (!m_mie || act == 0) return 32'h0;
    if (act[11]) return 32'h8000_000B;
    if (act[3])  return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  function automatic logic [31:0] m_trap_vector();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && trap_cause[31])
      return base + ((trap_cause & 32'h7FFF_FFFF) << 2);
    return base;
  endfunction

  // One rising edge worth of architectural effect, from the applied inputs
  task automatic model_tick();
    logic [31:0]     nv, old;
    logic [11:0]     a;
    longint unsigned cyc, ins;
    cyc = m_cycle + 1;
    ins = m_instret + (instret_inc ? 1 : 0);
    a = bus.wr_addr;
    if (trap_en) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret_en) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (bus.wr_op != 2'b00 && m_impl(a) && !m_ro(a)) begin
      old = m_read(a);
      case (bus.wr_op)
        2'b01:   nv = bus.wr_src;
        2'b10:   nv = old | bus.wr_src;
        default: nv = old & ~bus.wr_src;
      endcase
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv & 32'h888;
        12'h305: m_mtvec = nv[1] ? ((nv & ~32'h3) | (m_mtvec & 32'h3)) : nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: cyc = {m_cycle[63:32], nv};
        12'hB80: cyc = {nv, m_cycle[31:0]};
        12'hB02: ins = {m_instret[63:32], nv};
        12'hB82: ins = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle   = cyc & CNT_MASK;
    m_instret = ins & CNT_MASK;
    m_mip = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) |
            (irq_sw ? 32'h8 : 32'h0);
  endtask

  task automatic check_all();
    check("rd_data",     bus.rd_data,    m_read(bus.rd_addr));
    check("rd_illegal",  32'(bus.rd_illegal), 32'(!m_impl(bus.rd_addr)));
    check("wr_illegal",  32'(bus.wr_illegal),
          32'(bus.wr_op != 2'b00 && (!m_impl(bus.wr_addr) || m_ro(bus.wr_addr))));
    check("irq_pending", 32'(irq_pending), 32'(m_irq_cause() != 0));
    check("irq_cause",   irq_cause,      m_irq_cause());
    check("trap_vector", trap_vector,    m_trap_vector());
    check("mepc_out",    mepc_out,       m_mepc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wr_op = 2'b00; bus.wr_addr = 12'h000; bus.wr_src = 32'h0;
    trap_en = 0; mret_en = 0; instret_inc = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
    trap_pc = 0; trap_cause = 0; trap_tval = 0;
  endtask

  task automatic set_wr(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] s);
    bus.wr_op = op; bus.wr_addr = a; bus.wr_src = s;
  endtask

  // Check outputs for the applied inputs, then advance one clock
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic read_expect(input string tag, input logic [11:0] a,
                             input logic [31:0] exp);
    bus.rd_addr = a;
    #1 check(tag, bus.rd_data, exp);
  endtask

  logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
                                 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                 12'hB82, 12'hF14, 12'h7C0, 12'h306};

  // ---------------- stimulus ----------------
  initial begin
    idle();
    bus.rd_addr = 12'h000;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values
    read_expect("rst_mtvec",   12'h305, MTVEC_RST);
    read_expect("rst_mstatus", 12'h300, 32'h0000_1800);
    read_expect("rst_mhartid", 12'hF14, HART_ID);
    read_expect("unimpl_data", 12'h7C0, 32'h0);
    check("unimpl_illegal", 32'(bus.rd_illegal), 32'd1);
    check("rst_irq_pending", 32'(irq_pending), 32'd0);

    // mscratch RW / RS / RC
    set_wr(2'b01, 12'h340, 32'hA5A5_0000); tick();
    set_wr(2'b10, 12'h340, 32'h0000_00FF); tick();
    set_wr(2'b11, 12'h340, 32'hA500_0000); tick();
    idle();
    read_expect("mscratch_rmw", 12'h340, 32'h00A5_00FF);

    // Interrupt, vectored trap, mret
    set_wr(2'b10, 12'h300, 32'h8);     tick();
    set_wr(2'b01, 12'h304, 32'h800);   tick();
    set_wr(2'b01, 12'h305, 32'h1001);  tick();
    idle(); irq_ext = 1;               tick();
    idle();
    #1 check("irq_pending_ext", 32'(irq_pending), 32'd1);
    check("irq_cause_ext", irq_cause, 32'h8000_000B);
    trap_en = 1; trap_pc = 32'h104; trap_cause = 32'h8000_000B;
    #1 check("trap_vector_vec", trap_vector, 32'h0000_102C);
    tick();
    idle();
    #1 check("trap_mepc", mepc_out, 32'h104);
    read_expect("trap_mstatus", 12'h300, 32'h0000_1880);
    mret_en = 1; tick(); idle();
    read_expect("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap beats a same-cycle write and a same-cycle mret
    trap_en = 1; trap_pc = 32'h200; trap_cause = 32'h2;
    set_wr(2'b01, 12'h341, 32'h0000_DEAD); tick(); idle();
    #1 check("trap_vs_write", mepc_out, 32'h200);
    mret_en = 1; tick(); idle();
    trap_en = 1; mret_en = 1; trap_pc = 32'h300; trap_cause = 32'h5;
    tick(); idle();
    read_expect("trap_vs_mret", 12'h300, 32'h0000_1880);

    // Illegal-write detection
    set_wr(2'b01, 12'hF14, 32'h1234_5678);
    #1 check("wr_illegal_hartid", 32'(bus.wr_illegal), 32'd1);
    tick(); idle();
    read_expect("hartid_kept", 12'hF14, HART_ID);
    set_wr(2'b10, 12'h340, 32'h0);
    #1 check("rs_zero_legal", 32'(bus.wr_illegal), 32'd0);
    set_wr(2'b10, 12'h301, 32'h0);
    #1 check("rs_zero_ro", 32'(bus.wr_illegal), 32'd1);
    set_wr(2'b01, 12'hB00, 32'h0);
    #1 check("cnt_wr_legal", 32'(bus.wr_illegal), 32'd0);
    idle();

    // Counters
`ifdef CSR_COUNTERS_EN
    set_wr(2'b01, 12'hB00, 32'hFFFF_FFFE); tick();
    set_wr(2'b01, 12'hB80, 32'h0);         tick();
    idle();
    repeat (3) tick();
    read_expect("mcycleh_carry", 12'hB80, 32'h1);
    read_expect("mcycle_wrap",   12'hB00, 32'h1);
`else
    repeat (100) tick();
    read_expect("mcycle_absent", 12'hB00, 32'h0);
    check("mcycle_absent_legal", 32'(bus.rd_illegal), 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.rd_addr = addr_tab[$urandom_range(0, 15)];
      set_wr(2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, 15)], $urandom());
      trap_en     = ($urandom_range(0, 9) == 0);
      mret_en     = ($urandom_range(0, 7) == 0);
      instret_inc = 1'($urandom_range(0, 1));
      irq_sw      = 1'($urandom_range(0, 1));
      irq_timer   = 1'($urandom_range(0, 1));
      irq_ext     = ($urandom_range(0, 3) == 0);
      trap_pc     = $urandom();
      trap_cause  = $urandom_range(0, 1) ? {1'b1, 27'h0, 4'($urandom_range(0, 15))}
                                         : {1'b0, 31'($urandom_range(0, 15))};
      trap_tval   = $urandom();
      tick();
    end

    // Asynchronous reset in the middle of traffic
    idle();
    set_wr(2'b01, 12'h340, 32'h1111_2222);
    #3 rst_n = 1'b0;
    model_reset();
    read_expect("midrst_mtvec", 12'h305, MTVEC_RST);
    read_expect("midrst_mscratch", 12'h340, 32'h0);
    read_expect("midrst_mcycle", 12'hB00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 20; i++) begin
      bus.rd_addr = addr_tab[$urandom_range(0, 15)];
      instret_inc = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
